// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with a valid/ready output stage and a 2-entry skid buffer.
// Optional reduction outputs (red = {^z, |z, &z}) are enabled with LOGIC_UNIT_PIPE_REDUCE_EN.
module logic_unit_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             zero
`ifdef LOGIC_UNIT_PIPE_REDUCE_EN
  ,
  output logic [2:0]       red
`endif
);

`ifdef LOGIC_UNIT_PIPE_REDUCE_EN
  localparam int PW = WIDTH + 3;
`else
  localparam int PW = WIDTH;
`endif

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] logic_op(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [2:0]       o);
    logic [WIDTH-1:0] r;
    case (o)
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b010:  r = a ^ b;
      3'b011:  r = ~(a & b);
      3'b100:  r = ~(a | b);
      3'b101:  r = ~(a ^ b);
      3'b110:  r = ~a;
      default: r = a;
    endcase
    return r;
  endfunction

  state_t          state_q, state_d;
  logic [PW-1:0]   m_q, m_d;
  logic [PW-1:0]   s_q, s_d;
  logic            in_ready_q, in_ready_d;
  logic [WIDTH-1:0] res;
  logic [PW-1:0]   res_pl;
  logic            accept;
  logic            transfer;

  // Payload carries the result plus, when enabled, its reduction bits on top.
  always_comb begin
    res = logic_op(x, y, op);
`ifdef LOGIC_UNIT_PIPE_REDUCE_EN
    res_pl = {^res, |res, &res, res};
`else
    res_pl = res;
`endif
  end

  assign accept   = in_valid && in_ready_q;
  assign transfer = (state_q != EMPTY) && out_ready;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          m_d     = res_pl;
        end
      end
      ONE: begin
        if (accept && transfer) begin
          m_d = res_pl;
        end else if (accept) begin
          state_d = TWO;
          s_d     = res_pl;
        end else if (transfer) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (transfer) begin
          state_d = ONE;
          m_d     = s_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      m_q        <= '0;
      s_q        <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      s_q        <= s_d;
      in_ready_q <= in_ready_d;
    end
  end

  // M may hold a stale value once drained, so zero is gated by out_valid.
  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign z         = m_q[WIDTH-1:0];
  assign zero      = out_valid && (m_q[WIDTH-1:0] == '0);
`ifdef LOGIC_UNIT_PIPE_REDUCE_EN
  assign red       = m_q[PW-1:WIDTH];
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe (WIDTH=8): table vectors plus skid/reset sequences,
// with a scoreboard queue filled on accept and drained on transfer.
module tb_logic_unit_pipe;

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] op;
    logic [7:0] z;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] x;
  logic [7:0] y;
  logic [2:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] z;
  logic       zero;
`ifdef LOGIC_UNIT_PIPE_REDUCE_EN
  logic [2:0] red;
`endif

  int tests = 0;
  int fails = 0;
  int out_cnt = 0;
  logic [7:0] exp_cur;
  logic [7:0] sb[$];

  logic_unit_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .zero      (zero)
`ifdef LOGIC_UNIT_PIPE_REDUCE_EN
    ,
    .red       (red)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] o);
    logic [7:0] r;
    case (o)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = ~(a & b);
      3'd4: r = ~(a | b);
      3'd5: r = ~(a ^ b);
      3'd6: r = ~a;
      default: r = a;
    endcase
    return r;
  endfunction

  // Transfer is retired before the accept is recorded, so FIFO order is kept.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", {24'd0, z}, 32'hFFFF_FFFF);
        end else begin
          logic [7:0] e;
          e = sb.pop_front();
          out_cnt++;
          chk("z", {24'd0, z}, {24'd0, e});
          chk("zero", {31'd0, zero}, {31'd0, (e == 8'h00)});
`ifdef LOGIC_UNIT_PIPE_REDUCE_EN
          chk("red", {29'd0, red}, {29'd0, ^e, |e, &e});
`endif
        end
      end
      if (in_valid && in_ready) sb.push_back(exp_cur);
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o,
                      input logic [7:0] e, output int n);
    logic acc;
    x = a; y = b; op = o; exp_cur = e; in_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", sb.size(), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[8];
    int   n;
    int   base;
    vt[0] = '{8'hA5, 8'h0F, 3'd0, 8'h05};
    vt[1] = '{8'hA5, 8'h0F, 3'd1, 8'hAF};
    vt[2] = '{8'hA5, 8'h0F, 3'd2, 8'hAA};
    vt[3] = '{8'hA5, 8'h0F, 3'd3, 8'hFA};
    vt[4] = '{8'hA5, 8'h0F, 3'd4, 8'h50};
    vt[5] = '{8'hA5, 8'h0F, 3'd5, 8'h55};
    vt[6] = '{8'hA5, 8'h0F, 3'd6, 8'h5A};
    vt[7] = '{8'hA5, 8'h0F, 3'd7, 8'hA5};

    rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; op = '0; out_ready = 1'b0; exp_cur = '0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_z", {24'd0, z}, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);
    #11 rst = 1'b0;
    #1 chk("in_ready_before_edge", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("in_ready_after_edge", {31'd0, in_ready}, 32'd1);

    // Single op with one-cycle latency
    out_ready = 1'b1;
    send(8'hF0, 8'h3C, 3'd0, 8'h30, n);
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_out_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_z", {24'd0, z}, 32'h30);
    chk("lat_in_ready", {31'd0, in_ready}, 32'd1);
    drain();

    // All opcodes back to back
    for (int i = 0; i < 8; i++) begin
      send(vt[i].x, vt[i].y, vt[i].op, vt[i].z, n);
      chk("no_bubble", n, 32'd1);
    end
    in_valid = 1'b0;
    drain();

    // Backpressure into the skid register
    base = out_cnt;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 4; i++) begin
          send(8'(i), 8'h00, 3'd2, ref_fn(8'(i), 8'h00, 3'd2), n);
        end
        in_valid = 1'b0;
      end
      begin
        @(negedge clk);
        @(negedge clk);
        chk("stall_z_a", {24'd0, z}, 32'd1);
        @(negedge clk);
        chk("stall_z_b", {24'd0, z}, 32'd1);
        chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("skid_count", out_cnt - base, 32'd4);

    // Zero flag both ways
    send(8'hFF, 8'hFF, 3'd2, ref_fn(8'hFF, 8'hFF, 3'd2), n);
    send(8'h00, 8'h00, 3'd4, ref_fn(8'h00, 8'h00, 3'd4), n);
    in_valid = 1'b0;
    drain();

    // Asynchronous reset while full
    out_ready = 1'b0;
    send(8'h11, 8'h22, 3'd1, ref_fn(8'h11, 8'h22, 3'd1), n);
    send(8'h33, 8'h0F, 3'd0, ref_fn(8'h33, 8'h0F, 3'd0), n);
    in_valid = 1'b0;
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_z", {24'd0, z}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
    sb.delete();
    @(negedge clk); #2 rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_stale", {31'd0, out_valid}, 32'd0);
    end
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Pipeline still works after reset
    send(8'h3C, 8'hFF, 3'd5, ref_fn(8'h3C, 8'hFF, 3'd5), n);
    in_valid = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, registered bitwise logic unit and the successor to the single-bit two-input AND gate. Two WIDTH-bit operands are combined under a 3-bit opcode: AND, OR, XOR, NAND, NOR, XNOR, NOT or PASS. The result is delivered through a valid/ready pipeline stage with a 2-entry skid buffer, so the block drops into streaming datapaths with full throughput and a registered `in_ready`.

## Interface
- `WIDTH`, default 8: operand and result width in bits, must be ≥ 1.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operands and opcode valid.
- `in_ready`  out  1  block can accept; registered.
- `x`  in  WIDTH  operand A.
- `y`  in  WIDTH  operand B.
- `op`  in  3  opcode.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts.
- `z`  out  WIDTH  result.
- `zero`  out  1  high when `z` is all zeros; qualified by `out_valid`.

## Operation
- Opcodes, all bitwise:
  - 3'b000 = x&y
  - 3'b001 = x|y
  - 3'b010 = x^y
  - 3'b011 = ~(x&y)
  - 3'b100 = ~(x|y)
  - 3'b101 = ~(x^y)
  - 3'b110 = ~x
  - 3'b111 = x (y ignored)
- The result is computed combinationally from the inputs and captured on accept. No arithmetic; all widths are WIDTH, with no extension or truncation.
- Accept = `in_valid && in_ready`. Transfer = `out_valid && out_ready`.
- Storage is a main register (M), which drives `z`, `zero` and `out_valid`, plus a skid register (S).
- States are EMPTY (M and S empty), ONE (M full) and TWO (M and S full).
- Transitions:
  - EMPTY + accept → ONE.
  - ONE + accept, no transfer → TWO (new entry goes to S).
  - ONE + accept + transfer → ONE (new entry goes to M).
  - ONE + transfer, no accept → EMPTY.
  - TWO + transfer → ONE (S moves to M).
  - TWO never accepts.
- `in_ready` is registered: next value = 0 when next state is TWO, else 1.
- Data order is strictly FIFO. No entry is dropped or duplicated.
- `z` and `zero` hold stable while `out_valid && !out_ready`.

## Timing
- Latency is 1 cycle: a result accepted at edge N appears on `z` with `out_valid=1` after edge N.
- Throughput is 1 result/cycle while `out_ready` stays high.
- After one stall cycle with input streaming, `in_ready` drops the next cycle. It returns to 1 the cycle after the TWO → ONE transfer.
- Reset values, applied immediately on `rst` assertion regardless of clock:
  - state EMPTY
  - `out_valid`=0
  - `z`=0
  - `zero`=0
  - `in_ready`=0
  - S contents 0
- `in_ready` rises at the first `clk` edge after `rst` deasserts.
- Reset mid-operation discards all held entries. No transfer completes in the reset cycle.
- Simultaneous accept and transfer in ONE is legal and must not stall.
- `op` values are all defined; there is no illegal-opcode case.

## Configuration
- `LOGIC_UNIT_PIPE_REDUCE_EN` defined:
  - Adds output port `red` (3 bits) = {^z, |z, &z}.
  - `red` is registered alongside `z` in both M and S, so it has the same latency and stall behaviour.
  - Reset value is 3'b000.
- Not defined: the `red` port and its storage are absent. All other behaviour is identical.

## Test plan
- Reset then single op: deassert `rst`, hold `out_ready`=1, send x=8'hF0, y=8'h3C, op=000 → `z`=8'h30, `zero`=0 one cycle later, `in_ready`=1 throughout after the first post-reset edge.
- All opcodes: x=8'hA5, y=8'h0F, `out_ready`=1 → results in order 05, AF, AA, FA, 50, 55, 5A, A5. Back-to-back, one per cycle, no bubbles.
- Backpressure/skid:
  - Stream op=010 with x=1,2,3,4 and y=0.
  - `out_ready`=0 for 3 cycles → `in_ready` falls after the 2nd accept; `z`=1 holds.
  - Release → outputs 1,2,3,4 in order, with no loss or duplication.
- Zero flag: x=8'hFF, y=8'hFF, op=010 → `z`=8'h00, `zero`=1. Then op=100 with x=y=0 → `z`=8'hFF, `zero`=0.
- Reset mid-operation:
  - Fill to TWO with `out_ready`=0, then pulse `rst` asynchronously between edges.
  - `out_valid`, `z` and `in_ready` go to 0 immediately.
  - After release, no stale data appears.
- With `LOGIC_UNIT_PIPE_REDUCE_EN`, WIDTH=4: x=4'hF, y=4'h7, op=000 → `z`=4'h7, `red`=3'b110. Then op=111 → `z`=4'hF, `red`=3'b011.
